// File: rtl/spi_lcd_fill.sv
// Rectangle-fill engine: streams CASET/PASET/RAMWR plus colour bytes, band by band,
// into a byte serializer through a one-outstanding-byte we/done handshake.
module spi_lcd_fill #(
    parameter int         MAX_W     = 240,
    parameter int         MAX_H     = 320,
    parameter int         BAND_ROWS = 8,
    parameter int         BPP       = 2,
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_PASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_x0,
    input  logic [15:0] i_x1,
    input  logic [15:0] i_y0,
    input  logic [15:0] i_y1,
    input  logic [23:0] i_color,
    input  logic        i_byte_done,
    output logic [7:0]  o_byte,
    output logic        o_dc,
    output logic        o_we,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int          CNT_W    = $clog2(MAX_W * BAND_ROWS * BPP + 1);
    localparam logic [15:0] MAX_W16  = 16'(MAX_W);
    localparam logic [15:0] MAX_H16  = 16'(MAX_H);
    localparam logic [1:0]  LAST_SEL = 2'(BPP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CASET,
        S_PASET,
        S_RAMWR
    } state_t;

    state_t             state_q;
    logic [15:0]        x0_q, x1_q, y1_q, yb_q, ye_q;
    logic [23:0]        color_q;
    logic [2:0]         arg_q;
    logic [1:0]         bsel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               abort_q;
    logic [7:0]         byte_q;
    logic               dc_q, we_q, busy_q, done_q, err_q;

    logic               stop_d;
    logic               region_bad_d;
    logic [15:0]        next_yb_d;
    logic [7:0]         arg_byte_d;
    logic [1:0]         sel_d;
    logic [7:0]         pix_byte_d;
    logic [CNT_W-1:0]   cols_d, rows_d, n_d;

    // Last row of a band starting at base; clipped to the region before any 16-bit wrap.
    function automatic logic [15:0] band_end(input logic [15:0] base, input logic [15:0] last);
        logic [16:0] lim;
        lim = {1'b0, base} + 17'(BAND_ROWS - 1);
        return (lim >= {1'b0, last}) ? last : lim[15:0];
    endfunction

    always_comb begin
        stop_d       = i_abort | abort_q;
        region_bad_d = (x0_q > x1_q) || (yb_q > y1_q) || (x1_q >= MAX_W16) || (y1_q >= MAX_H16);
        next_yb_d    = ye_q + 16'd1;
        cols_d       = CNT_W'(x1_q - x0_q) + CNT_W'(1);
        rows_d       = CNT_W'(ye_q - yb_q) + CNT_W'(1);
        n_d          = cols_d * rows_d * CNT_W'(BPP);

        // arg_q indexes the byte still outstanding; this is the one after it.
        case (arg_q)
            3'd0:    arg_byte_d = (state_q == S_CASET) ? x0_q[15:8] : yb_q[15:8];
            3'd1:    arg_byte_d = (state_q == S_CASET) ? x0_q[7:0]  : yb_q[7:0];
            3'd2:    arg_byte_d = (state_q == S_CASET) ? x1_q[15:8] : ye_q[15:8];
            default: arg_byte_d = (state_q == S_CASET) ? x1_q[7:0]  : ye_q[7:0];
        endcase

        if (arg_q == 3'd0 || bsel_q == LAST_SEL) begin
            sel_d = 2'd0;
        end else begin
            sel_d = bsel_q + 2'd1;
        end

        if (BPP == 3) begin
            case (sel_d)
                2'd0:    pix_byte_d = color_q[23:16];
                2'd1:    pix_byte_d = color_q[15:8];
                default: pix_byte_d = color_q[7:0];
            endcase
        end else begin
            pix_byte_d = (sel_d == 2'd0) ? color_q[15:8] : color_q[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            yb_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            arg_q   <= '0;
            bsel_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            byte_q  <= '0;
            dc_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (busy_q && i_abort) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        x0_q    <= i_x0;
                        x1_q    <= i_x1;
                        yb_q    <= i_y0;
                        y1_q    <= i_y1;
                        color_q <= i_color;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (region_bad_d || stop_d) begin
                        done_q  <= 1'b1;
                        err_q   <= region_bad_d;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        ye_q    <= band_end(yb_q, y1_q);
                        byte_q  <= CMD_CASET;
                        dc_q    <= 1'b0;
                        we_q    <= 1'b1;
                        arg_q   <= 3'd0;
                        state_q <= S_CASET;
                    end
                end

                S_CASET, S_PASET: begin
                    if (i_byte_done) begin
                        if (stop_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            abort_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (arg_q == 3'd4) begin
                            byte_q  <= (state_q == S_CASET) ? CMD_PASET : CMD_RAMWR;
                            dc_q    <= 1'b0;
                            we_q    <= 1'b1;
                            arg_q   <= 3'd0;
                            state_q <= (state_q == S_CASET) ? S_PASET : S_RAMWR;
                        end else begin
                            byte_q <= arg_byte_d;
                            dc_q   <= 1'b1;
                            we_q   <= 1'b1;
                            arg_q  <= arg_q + 3'd1;
                        end
                    end
                end

                S_RAMWR: begin
                    if (i_byte_done) begin
                        if (stop_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            abort_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (arg_q != 3'd0 && cnt_q == '0) begin
                            if (ye_q == y1_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                yb_q    <= next_yb_d;
                                ye_q    <= band_end(next_yb_d, y1_q);
                                byte_q  <= CMD_CASET;
                                dc_q    <= 1'b0;
                                we_q    <= 1'b1;
                                arg_q   <= 3'd0;
                                state_q <= S_CASET;
                            end
                        end else begin
                            // cnt_q holds the pixel bytes still to issue after this one.
                            byte_q <= pix_byte_d;
                            dc_q   <= 1'b1;
                            we_q   <= 1'b1;
                            bsel_q <= sel_d;
                            arg_q  <= 3'd1;
                            cnt_q  <= (arg_q == 3'd0) ? n_d - CNT_W'(1) : cnt_q - CNT_W'(1);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_byte = byte_q;
    assign o_dc   = dc_q;
    assign o_we   = we_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_spi_lcd_fill.sv
// Directed bench for spi_lcd_fill: a BPP=2 and a BPP=3 instance share one serializer model
// that answers each o_we with an i_byte_done pulse after a programmable gap.
module tb_spi_lcd_fill;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_start3, i_abort, i_byte_done;
    logic [15:0] i_x0, i_x1, i_y0, i_y1;
    logic [23:0] i_color;
    logic [7:0]  o_byte, o_byte3;
    logic        o_dc, o_we, o_busy, o_done, o_err;
    logic        o_dc3, o_we3, o_busy3, o_done3, o_err3;

    spi_lcd_fill #(.BPP(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1), .i_color(i_color),
        .i_byte_done(i_byte_done), .o_byte(o_byte), .o_dc(o_dc), .o_we(o_we),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    spi_lcd_fill #(.BPP(3)) dut3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start3), .i_abort(i_abort),
        .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1), .i_color(i_color),
        .i_byte_done(i_byte_done), .o_byte(o_byte3), .o_dc(o_dc3), .o_we(o_we3),
        .o_busy(o_busy3), .o_done(o_done3), .o_err(o_err3)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int nchk = 0;
    int nfail = 0;
    int gap = 1;
    int rcnt = 0;
    int q_byte[$];
    int q_dc[$];
    int q_cyc[$];
    int eb[$];
    int ed[$];

    // Serializer model: logs every issued byte and answers it gap cycles later.
    initial begin
        i_byte_done = 1'b0;
        forever begin
            @(negedge i_clk);
            i_byte_done = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) i_byte_done = 1'b1;
            end
            if (o_we || o_we3) begin
                q_byte.push_back(o_we ? int'(o_byte) : int'(o_byte3));
                q_dc.push_back(o_we ? int'(o_dc) : int'(o_dc3));
                q_cyc.push_back(cyc);
                rcnt = gap;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_cmd(input int cmd, input int a, input int b);
        eb.push_back(cmd);            ed.push_back(0);
        eb.push_back((a >> 8) & 255); ed.push_back(1);
        eb.push_back(a & 255);        ed.push_back(1);
        eb.push_back((b >> 8) & 255); ed.push_back(1);
        eb.push_back(b & 255);        ed.push_back(1);
    endtask

    task automatic exp_px(input int npix, input int bpp, input int color);
        for (int p = 0; p < npix; p++) begin
            if (bpp == 3) begin
                eb.push_back((color >> 16) & 255); ed.push_back(1);
            end
            eb.push_back((color >> 8) & 255); ed.push_back(1);
            eb.push_back(color & 255);        ed.push_back(1);
        end
    endtask

    task automatic exp_ramwr();
        eb.push_back(8'h2C); ed.push_back(0);
    endtask

    task automatic cmp_stream(input string tag);
        int mb = 0;
        int md = 0;
        int n;
        chk({tag, "_len"}, q_byte.size(), eb.size());
        n = (q_byte.size() < eb.size()) ? q_byte.size() : eb.size();
        for (int i = 0; i < n; i++) begin
            if (q_byte[i] != eb[i]) mb++;
            if (q_dc[i] != ed[i]) md++;
        end
        chk({tag, "_byte_diffs"}, mb, 0);
        chk({tag, "_dc_diffs"}, md, 0);
        eb.delete();
        ed.delete();
    endtask

    task automatic clear_log();
        q_byte.delete();
        q_dc.delete();
        q_cyc.delete();
    endtask

    // Pulses start for one cycle, then scrambles the inputs to prove they were latched.
    task automatic start_fill(input int x0, input int x1, input int y0, input int y1,
                              input int color, input bit use3, output int scyc);
        @(negedge i_clk);
        clear_log();
        i_x0 = 16'(x0); i_x1 = 16'(x1); i_y0 = 16'(y0); i_y1 = 16'(y1);
        i_color = 24'(color);
        if (use3) i_start3 = 1'b1;
        else      i_start  = 1'b1;
        scyc = cyc;
        @(negedge i_clk);
        i_start = 1'b0; i_start3 = 1'b0;
        i_x0 = 16'hFFFF; i_x1 = 16'h0000; i_y0 = 16'hFFFF; i_y1 = 16'h0000;
        i_color = 24'h5A5A5A;
    endtask

    task automatic wait_done(input string tag, input bit use3, input int limit,
                             output int dcyc, output int err);
        dcyc = -1;
        err  = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_clk);
            if (use3 ? o_done3 : o_done) begin
                dcyc = cyc;
                err  = use3 ? int'(o_err3) : int'(o_err);
                chk({tag, "_busy_at_done"}, use3 ? o_busy3 : o_busy, 1'b0);
                break;
            end
        end
        chk({tag, "_done_seen"}, dcyc >= 0, 1'b1);
    endtask

    int scyc, dcyc, err, w, nres;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_start3 = 1'b0; i_abort = 1'b0;
        i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0; i_color = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_outputs", {o_byte, o_dc, o_we, o_busy, o_done, o_err}, 32'd0);
        chk("rst_outputs3", {o_byte3, o_dc3, o_we3, o_busy3, o_done3, o_err3}, 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // A: 3x10 rect, two bands (rows 5..12, 13..14)
        gap = 1;
        start_fill(10, 12, 5, 14, 24'h0007E0, 1'b0, scyc);
        chk("A_busy_in_check", o_busy, 1'b1);
        wait_done("A", 1'b0, 500, dcyc, err);
        exp_cmd(8'h2A, 10, 12); exp_cmd(8'h2B, 5, 12); exp_ramwr(); exp_px(24, 2, 24'h07E0);
        exp_cmd(8'h2A, 10, 12); exp_cmd(8'h2B, 13, 14); exp_ramwr(); exp_px(6, 2, 24'h07E0);
        cmp_stream("A");
        chk("A_first_we_cycle", q_cyc[0], scyc + 2);
        chk("A_we_spacing", q_cyc[1] - q_cyc[0], 2);
        chk("A_done_cycle", dcyc, q_cyc[q_cyc.size() - 1] + 2);
        chk("A_err", err, 0);
        $display("fill A rect 10..12 x 5..14: %0d bytes, done at cycle %0d", q_byte.size(), dcyc);

        // B: BPP=3 single pixel at the far corner
        start_fill(239, 239, 319, 319, 24'h123456, 1'b1, scyc);
        wait_done("B", 1'b1, 200, dcyc, err);
        exp_cmd(8'h2A, 239, 239); exp_cmd(8'h2B, 319, 319); exp_ramwr(); exp_px(1, 3, 24'h123456);
        cmp_stream("B");
        chk("B_first_we_cycle", q_cyc[0], scyc + 2);
        chk("B_err", err, 0);
        $display("fill B 1x1 at 239,319 bpp3: %0d bytes, done at cycle %0d", q_byte.size(), dcyc);

        // C: full width, last two bands of the panel
        start_fill(0, 239, 304, 319, 24'h00F800, 1'b0, scyc);
        wait_done("C", 1'b0, 20000, dcyc, err);
        exp_cmd(8'h2A, 0, 239); exp_cmd(8'h2B, 304, 311); exp_ramwr(); exp_px(1920, 2, 24'hF800);
        exp_cmd(8'h2A, 0, 239); exp_cmd(8'h2B, 312, 319); exp_ramwr(); exp_px(1920, 2, 24'hF800);
        cmp_stream("C");
        chk("C_err", err, 0);
        $display("fill C 0..239 x 304..319: %0d bytes, done at cycle %0d", q_byte.size(), dcyc);

        // D: rejected regions and abort in the check cycle
        start_fill(20, 10, 0, 0, 24'h0, 1'b0, scyc);
        wait_done("D1", 1'b0, 20, dcyc, err);
        chk("D1_done_cycle", dcyc, scyc + 2);
        chk("D1_err", err, 1);
        chk("D1_no_bytes", q_byte.size(), 0);
        $display("fill D1 x0>x1: err=%0d done at cycle %0d", err, dcyc);

        start_fill(0, 0, 0, 320, 24'h0, 1'b0, scyc);
        wait_done("D2", 1'b0, 20, dcyc, err);
        chk("D2_done_cycle", dcyc, scyc + 2);
        chk("D2_err", err, 1);
        chk("D2_no_bytes", q_byte.size(), 0);
        $display("fill D2 y1=320: err=%0d done at cycle %0d", err, dcyc);

        start_fill(0, 240, 0, 0, 24'h0, 1'b1, scyc);
        i_abort = 1'b1;
        wait_done("D3", 1'b1, 20, dcyc, err);
        i_abort = 1'b0;
        chk("D3_done_cycle", dcyc, scyc + 2);
        chk("D3_err", err, 1);
        chk("D3_no_bytes", q_byte.size(), 0);
        $display("fill D3 x1=240 with abort: err=%0d done at cycle %0d", err, dcyc);

        start_fill(1, 2, 3, 4, 24'h0, 1'b0, scyc);
        i_abort = 1'b1;
        wait_done("D4", 1'b0, 20, dcyc, err);
        i_abort = 1'b0;
        chk("D4_done_cycle", dcyc, scyc + 2);
        chk("D4_err", err, 0);
        chk("D4_no_bytes", q_byte.size(), 0);
        $display("fill D4 valid region aborted in check: err=%0d done at cycle %0d", err, dcyc);

        // E: abort mid-RAMWR with a byte outstanding
        gap = 6;
        start_fill(10, 12, 5, 14, 24'h0007E0, 1'b0, scyc);
        for (int i = 0; i < 300 && q_byte.size() < 15; i++) @(negedge i_clk);
        chk("E_reached_pixels", q_byte.size(), 15);
        i_abort = 1'b1;
        w = q_cyc[14];
        wait_done("E", 1'b0, 100, dcyc, err);
        i_abort = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("E_no_more_we", q_byte.size(), 15);
        chk("E_done_cycle", dcyc, w + 7);
        chk("E_err", err, 0);
        $display("fill E abort mid-RAMWR: %0d bytes, done at cycle %0d", q_byte.size(), dcyc);
        gap = 1;

        // F: start while busy is ignored, then reset mid-band and restart
        start_fill(10, 12, 5, 14, 24'h0007E0, 1'b0, scyc);
        for (int i = 0; i < 100 && q_byte.size() < 3; i++) @(negedge i_clk);
        i_x0 = 16'd0; i_x1 = 16'd1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 100 && q_byte.size() < 20; i++) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("F_rst_outputs", {o_byte, o_dc, o_we, o_busy, o_done, o_err}, 32'd0);
        exp_cmd(8'h2A, 10, 12);
        for (int i = 0; i < 5; i++) begin
            if (i < q_byte.size()) begin
                chk("F_caset_unchanged", q_byte[i], eb[i]);
            end
        end
        eb.delete(); ed.delete();
        nres = q_byte.size();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("F_quiet_after_rst", q_byte.size(), nres);
        start_fill(5, 5, 7, 7, 24'h00ABCD, 1'b0, scyc);
        wait_done("F", 1'b0, 200, dcyc, err);
        exp_cmd(8'h2A, 5, 5); exp_cmd(8'h2B, 7, 7); exp_ramwr(); exp_px(1, 2, 24'hABCD);
        cmp_stream("F");
        chk("F_first_we_cycle", q_cyc[0], scyc + 2);
        chk("F_err", err, 0);
        $display("fill F restart after reset 1x1 at 5,7: %0d bytes, done at cycle %0d",
                 q_byte.size(), dcyc);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
